// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int FIFO_DSIZE_DEF = 8;
  localparam int FIFO_ASIZE_DEF = 4;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake, status and error signals of sync_fifo; master drives requests, slave is the FIFO.
interface sync_fifo_if import fifo_pkg::*; #(
  parameter int DSIZE = FIFO_DSIZE_DEF,
  parameter int ASIZE = FIFO_ASIZE_DEF
) ();

  logic             winc;
  logic [DSIZE-1:0] wData;
  logic             rinc;
  logic [DSIZE-1:0] rData;
  logic             wFull;
  logic             rEmpty;
  logic             wAlmostFull;
  logic             rAlmostEmpty;
  logic [ASIZE:0]   count;
  logic             clr_err;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wData, rinc, clr_err,
    input  rData, wFull, rEmpty, wAlmostFull, rAlmostEmpty, count, overflow, underflow
  );

  modport slave (
    input  winc, wData, rinc, clr_err,
    output rData, wFull, rEmpty, wAlmostFull, rAlmostEmpty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Storage array with one write and one read port; SYNC_RD=1 gives a reset read register
// loaded on re, SYNC_RD=0 gives a combinational read of raddr.
module sync_fifo_mem import fifo_pkg::*; #(
  parameter int DSIZE   = FIFO_DSIZE_DEF,
  parameter int ASIZE   = FIFO_ASIZE_DEF,
  parameter bit SYNC_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             re,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (SYNC_RD) begin : g_sync_rd
    logic [DSIZE-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_rd
    // The head stage upstream owns the read timing here.
    logic unused_rd;
    assign unused_rd = rst ^ re;
    assign rdata     = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact count, almost flags and sticky errors; 1-cycle read latency, writes dropped when full.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through: rData shows the head word whenever rEmpty is low.
module sync_fifo import fifo_pkg::*; #(
  parameter int DSIZE     = FIFO_DSIZE_DEF,
  parameter int ASIZE     = FIFO_ASIZE_DEF,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int             DEPTH    = fifo_depth(ASIZE);
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);
  localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_param
    $error("sync_fifo: AFULL_TH or AEMPTY_TH outside legal range");
  end

  logic [ASIZE:0]   wptr, rptr, cnt;
  logic             full, empty, push, pop;
  logic             mem_we, mem_re;
  logic [DSIZE-1:0] mem_rdata;
  logic             ovf, unf;

  assign full = (cnt == DEPTH_C);
  assign push = bus.winc && !full;
  assign pop  = bus.rinc && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (mem_we) wptr <= wptr + ONE;
      if (mem_re) rptr <= rptr + ONE;
      if (push && !pop) begin
        cnt <= cnt + ONE;
      end else if (pop && !push) begin
        cnt <= cnt - ONE;
      end
      // A read that arrives with a write into an empty FIFO just loses to the write.
      ovf <= (bus.winc && full) || (ovf && !bus.clr_err);
      unf <= (bus.rinc && empty && !bus.winc) || (unf && !bus.clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit SYNC_RD = 1'b0;

  logic             head_vld, head_open, mem_empty, bypass;
  logic [DSIZE-1:0] head_dat;

  assign empty     = !head_vld;
  assign mem_empty = (wptr == rptr);
  assign head_open = !head_vld || pop;
  assign bypass    = head_open && mem_empty && push;
  assign mem_re    = head_open && !mem_empty;
  assign mem_we    = push && !bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_vld <= 1'b0;
      head_dat <= '0;
    end else if (mem_re) begin
      head_vld <= 1'b1;
      head_dat <= mem_rdata;
    end else if (bypass) begin
      head_vld <= 1'b1;
      head_dat <= bus.wData;
    end else if (pop) begin
      head_vld <= 1'b0;
    end
  end

  assign bus.rData = head_dat;
`else
  localparam bit SYNC_RD = 1'b1;

  assign empty     = (cnt == '0);
  assign mem_we    = push;
  assign mem_re    = pop;
  assign bus.rData = mem_rdata;
`endif

  sync_fifo_mem #(
    .DSIZE   (DSIZE),
    .ASIZE   (ASIZE),
    .SYNC_RD (SYNC_RD)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wptr[ASIZE-1:0]),
    .wdata (bus.wData),
    .re    (mem_re),
    .raddr (rptr[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

  assign bus.count        = cnt;
  assign bus.wFull        = full;
  assign bus.rEmpty       = empty;
  assign bus.wAlmostFull  = (cnt >= AFULL_C);
  assign bus.rAlmostEmpty = (cnt <= AEMPTY_C);
  assign bus.overflow     = ovf;
  assign bus.underflow    = unf;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2.
module tb_sync_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sync_fifo_if #(.DSIZE(8), .ASIZE(4)) bus ();

  sync_fifo #(
    .DSIZE     (8),
    .ASIZE     (4),
    .AFULL_TH  (14),
    .AEMPTY_TH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] d);
    bus.winc  = 1'b1;
    bus.wData = d;
    step();
    bus.winc  = 1'b0;
  endtask

  // Pops one word and checks it; optionally writes on the same edge.
  task automatic rd_word(input logic [7:0] exp, input bit wr, input logic [7:0] wd);
`ifdef SYNC_FIFO_FWFT_EN
    chk("head", 16'(bus.rData), 16'(exp));
`endif
    bus.rinc  = 1'b1;
    bus.winc  = wr;
    bus.wData = wd;
    step();
    bus.rinc  = 1'b0;
    bus.winc  = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    chk("rdata", 16'(bus.rData), 16'(exp));
`endif
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.winc     = 1'b0;
    bus.rinc     = 1'b0;
    bus.wData    = '0;
    bus.clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 16'(bus.count), 16'd0);
    chk("rst_empty", 16'(bus.rEmpty), 16'd1);
    chk("rst_full", 16'(bus.wFull), 16'd0);
    chk("rst_afull", 16'(bus.wAlmostFull), 16'd0);
    chk("rst_aempty", 16'(bus.rAlmostEmpty), 16'd1);
    chk("rst_ovf", 16'(bus.overflow), 16'd0);
    chk("rst_unf", 16'(bus.underflow), 16'd0);
    chk("rst_rdata", 16'(bus.rData), 16'd0);
    rst = 1'b1;

    // Build up state (underflow set, count 5, rData nonzero) then reset mid-stream.
    bus.rinc = 1'b1;
    step();
    bus.rinc = 1'b0;
    chk("pre_unf", 16'(bus.underflow), 16'd1);
    for (int i = 0; i < 5; i++) wr_word(8'(8'h11 + i));
    rd_word(8'h11, 1'b0, 8'h00);
    wr_word(8'h16);
    chk("pre_count", 16'(bus.count), 16'd5);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 16'(bus.count), 16'd0);
    chk("mid_rst_empty", 16'(bus.rEmpty), 16'd1);
    chk("mid_rst_aempty", 16'(bus.rAlmostEmpty), 16'd1);
    chk("mid_rst_ovf", 16'(bus.overflow), 16'd0);
    chk("mid_rst_unf", 16'(bus.underflow), 16'd0);
    chk("mid_rst_rdata", 16'(bus.rData), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to full, watching the threshold flags.
    for (int i = 1; i <= 16; i++) begin
      wr_word(8'(i));
      chk("fill_count", 16'(bus.count), 16'(i));
      chk("fill_afull", 16'(bus.wAlmostFull), 16'(i >= 14));
      chk("fill_full", 16'(bus.wFull), 16'(i == 16));
      chk("fill_aempty", 16'(bus.rAlmostEmpty), 16'(i <= 2));
      chk("fill_empty", 16'(bus.rEmpty), 16'd0);
    end

    bus.winc  = 1'b1;
    bus.wData = 8'hAA;
    step();
    bus.winc  = 1'b0;
    chk("ovf_count", 16'(bus.count), 16'd16);
    chk("ovf_set", 16'(bus.overflow), 16'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("ovf_clr", 16'(bus.overflow), 16'd0);

    // Drain; the first pop also attempts a write of 0xBB while full.
    for (int i = 1; i <= 16; i++) begin
      rd_word(8'(i), i == 1, 8'hBB);
      chk("drain_count", 16'(bus.count), 16'(16 - i));
      if (i == 1) begin
        chk("drain_ovf", 16'(bus.overflow), 16'd1);
        chk("drain_full", 16'(bus.wFull), 16'd0);
      end
    end
    chk("drain_empty", 16'(bus.rEmpty), 16'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;

    // Simultaneous write and read on empty: write wins, no underflow.
    bus.winc  = 1'b1;
    bus.rinc  = 1'b1;
    bus.wData = 8'h55;
    step();
    bus.winc  = 1'b0;
    bus.rinc  = 1'b0;
    chk("wr_rd_empty_count", 16'(bus.count), 16'd1);
    chk("wr_rd_empty_unf", 16'(bus.underflow), 16'd0);
    chk("wr_rd_empty_empty", 16'(bus.rEmpty), 16'd0);
    rd_word(8'h55, 1'b0, 8'h00);
    chk("wr_rd_empty_after", 16'(bus.count), 16'd0);

    // Steady state at count 8 with concurrent traffic.
    for (int i = 0; i < 8; i++) wr_word(8'(8'h20 + i));
    chk("steady_count0", 16'(bus.count), 16'd8);
    for (int k = 0; k < 20; k++) begin
      rd_word(8'(8'h20 + k), 1'b1, 8'(8'h28 + k));
      chk("steady_count", 16'(bus.count), 16'd8);
      chk("steady_flags", 16'({bus.wFull, bus.rEmpty, bus.wAlmostFull, bus.rAlmostEmpty}), 16'd0);
    end
    for (int k = 20; k < 28; k++) begin
      rd_word(8'(8'h20 + k), 1'b0, 8'h00);
      chk("tail_aempty", 16'(bus.rAlmostEmpty), 16'((27 - k) <= 2));
    end
    chk("tail_empty", 16'(bus.rEmpty), 16'd1);

    // Underflow with same-edge clear: set wins.
    bus.rinc    = 1'b1;
    bus.clr_err = 1'b1;
    step();
    bus.rinc    = 1'b0;
    chk("unf_set_wins", 16'(bus.underflow), 16'd1);
    chk("unf_count", 16'(bus.count), 16'd0);
    step();
    bus.clr_err = 1'b0;
    chk("unf_clr", 16'(bus.underflow), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
